// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// The FSM encoding and counter sizing live here so every file agrees on them.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit over $clog2 keeps a 1-bit minimum and avoids wrap within an operation.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/hA.sv
// Half-adder cell: sum and carry of two single bits.
module hA (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_fa_cell.sv
// Full-adder cell built from two half-adders; the carries never both fire, so OR suffices.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    hA u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    hA u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a carry flop.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   res_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_co;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    // Unused encoding 2'd3 behaves as IDLE, so it must also advertise ready.
    assign in_ready = rst_n && (state != BUSY) && (state != DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
        end else begin
            case (state)
                BUSY: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= res_next;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Sum       <= res_next;
                        Cout      <= fa_co;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    if (in_valid) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        res   <= '0;
                        state <= BUSY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder: an 8-bit instance and a 1-bit instance.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Sum;
    logic       Cout;

    logic       v1_in_valid;
    logic       v1_in_ready;
    logic [0:0] v1_A;
    logic [0:0] v1_B;
    logic       v1_Cin;
    logic       v1_out_valid;
    logic       v1_out_ready;
    logic [0:0] v1_Sum;
    logic       v1_Cout;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         acc_cyc[$];
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout)
    );

    serial_adder #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .A(v1_A), .B(v1_B), .Cin(v1_Cin), .out_valid(v1_out_valid),
        .out_ready(v1_out_ready), .Sum(v1_Sum), .Cout(v1_Cout)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output int e);
        e = 0;
        while (!out_valid && e < 40) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic check_result(input string tag);
        logic [8:0] exp;
        exp = exp_q.pop_front();
        check({tag, "_sum"}, 32'(Sum), 32'(exp[7:0]));
        check({tag, "_cout"}, 32'(Cout), 32'(exp[8]));
    endtask

    // driver: one full operation with out_ready held high
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
        int e;
        exp_q.push_back({exp_cout, exp_sum});
        wait_ready();
        A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(e);
        check({tag, "_latency"}, 32'(e), 32'd8);
        check_result(tag);
        @(negedge clk);
        check({tag, "_one_cycle"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int e;
        int n_acc;
        logic seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
        v1_in_valid = 1'b0; v1_out_ready = 1'b1; v1_A = '0; v1_B = '0; v1_Cin = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(Sum), 32'd0);
        check("rst_cout", 32'(Cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // FF + 01 wraps to zero with carry out
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

        // back-to-back with in_valid held high
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b0, 8'h7E});
        A = 8'h5A; B = 8'hA5; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        A = 8'h3C; B = 8'h42; Cin = 1'b0;
        wait_valid(e);
        check("b2b0_latency", 32'(e), 32'd8);
        check_result("b2b0");
        @(negedge clk);
        check("b2b_idle_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_accept_gap", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 32'd10);
        wait_valid(e);
        check("b2b1_latency", 32'(e), 32'd8);
        check_result("b2b1");
        @(negedge clk);

        // backpressure: result held for 5 cycles, new request refused
        exp_q.push_back({1'b0, 8'h46});
        out_ready = 1'b0;
        A = 8'h12; B = 8'h34; Cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(e);
        check("bp_latency", 32'(e), 32'd8);
        n_acc = acc_cyc.size();
        in_valid = 1'b1; A = 8'h11; B = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum_stable", 32'(Sum), 32'h46);
            check("bp_cout_stable", 32'(Cout), 32'd0);
            @(negedge clk);
        end
        check_result("bp");
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_no_accept", 32'(acc_cyc.size()), 32'(n_acc));

        // input hazard: pins churn during BUSY
        exp_q.push_back({1'b0, 8'h30});
        A = 8'h10; B = 8'h20; Cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        e = 0;
        while (!out_valid && e < 40) begin
            A = 8'($urandom_range(0, 255));
            B = 8'($urandom_range(0, 255));
            Cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            e++;
        end
        check("hz_latency", 32'(e), 32'd8);
        check_result("hz");
        @(negedge clk);

        // reset at bit 3 of BUSY discards the partial result
        A = 8'h77; B = 8'h11; Cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(Sum), 32'd0);
        check("mid_rst_cout", 32'(Cout), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // out_ready outside DONE has no effect on the next result
        out_ready = 1'b1;
        run_op("max", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // WIDTH=1 instance
        v1_A = 1'b1; v1_B = 1'b1; v1_Cin = 1'b1; v1_in_valid = 1'b1;
        @(negedge clk);
        v1_in_valid = 1'b0;
        e = 0;
        while (!v1_out_valid && e < 20) begin
            @(negedge clk);
            e++;
        end
        check("w1_latency", 32'(e), 32'd1);
        check("w1_sum", 32'(v1_Sum), 32'd1);
        check("w1_cout", 32'(v1_Cout), 32'd1);
        @(negedge clk);
        check("w1_one_cycle", 32'(v1_out_valid), 32'd0);
        v1_A = 1'b1; v1_B = 1'b0; v1_Cin = 1'b0; v1_in_valid = 1'b1;
        @(negedge clk);
        v1_in_valid = 1'b0;
        @(negedge clk);
        check("w1b_valid", 32'(v1_out_valid), 32'd1);
        check("w1b_sum", 32'(v1_Sum), 32'd1);
        check("w1b_cout", 32'(v1_Cout), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
